// File: rtl/wb_gpio_master_if.sv
// rtl/wb_gpio_master_if.sv - Wishbone classic bus bundle between the GPIO master and its slaves.
interface wb_gpio_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) ();
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_gpio_master.sv
// rtl/wb_gpio_master.sv - Single-outstanding Wishbone classic initiator with ack watchdog.
module wb_gpio_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  wb_gpio_master_if.master      wb
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, GAP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_dat_q;
  logic                  rsp_err_q;
  logic                  cmd_accept;

  assign cmd_accept = cmd_valid_i && cmd_ready_q;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_accept) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cyc_q       <= 1'b1;
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            cnt_q       <= '0;
            state_q     <= BUS;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        // Ack is tested first so an ack on the final watchdog cycle still completes cleanly.
        BUS: begin
          if (wb.wb_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : wb.wb_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= GAP;
          end
        end
        // One dead cycle lets a slave's registered, stale ack drain before the next strobe.
        GAP: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

endmodule
